// File: rtl/pc_unit.sv
// Program-counter unit: holds the architectural PC, selects the next PC by priority
// (trap, trap return, jump, branch, sequential), records trap state and counts retirements.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     IALIGN       = 4,
  parameter int unsigned     CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 jump,
  input  logic [XLEN-1:0]      jump_target,
  input  logic                 branch_taken,
  input  logic [XLEN-1:0]      branch_target,
  input  logic                 trap_req,
  input  logic [3:0]           trap_cause,
  input  logic                 trap_ret,
  output logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      pc_plus4,
  output logic [XLEN-1:0]      epc,
  output logic [3:0]           mcause,
  output logic [XLEN-1:0]      mtval,
  output logic                 trap_taken,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam logic [3:0]      CAUSE_MISALIGN = 4'd0;
  // Low address bits that must be zero for a legal fetch target.
  localparam logic [XLEN-1:0] ALIGN_MASK     = XLEN'(IALIGN - 1);

  logic [XLEN-1:0]      pc_d;
  logic [XLEN-1:0]      epc_d;
  logic [3:0]           mcause_d;
  logic [XLEN-1:0]      mtval_d;
  logic                 trap_taken_d;
  logic [CNT_WIDTH-1:0] retired_d;
  logic                 retire;
  logic [XLEN-1:0]      redirect_target;
  logic                 misaligned;

  assign pc_plus4 = pc + XLEN'(4);

  // Jump outranks branch; only the winning target is alignment-checked.
  assign redirect_target = jump ? jump_target : branch_target;
  assign misaligned      = |(redirect_target & ALIGN_MASK);

  // Next-state selection.
  always_comb begin
    pc_d         = pc;
    epc_d        = epc;
    mcause_d     = mcause;
    mtval_d      = mtval;
    trap_taken_d = 1'b0;
    retire       = 1'b0;
    if (!stall) begin
      if (trap_req) begin
        epc_d        = pc;
        mcause_d     = trap_cause;
        mtval_d      = '0;
        pc_d         = TRAP_VECTOR;
        trap_taken_d = 1'b1;
      end else if (trap_ret) begin
        pc_d   = epc;
        retire = 1'b1;
      end else if (jump || branch_taken) begin
        if (misaligned) begin
          epc_d        = pc;
          mcause_d     = CAUSE_MISALIGN;
          mtval_d      = redirect_target;
          pc_d         = TRAP_VECTOR;
          trap_taken_d = 1'b1;
        end else begin
          pc_d   = redirect_target;
          retire = 1'b1;
        end
      end else begin
        pc_d   = pc_plus4;
        retire = 1'b1;
      end
    end
    retired_d = retire ? retired + CNT_WIDTH'(1) : retired;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_VECTOR;
      epc        <= '0;
      mcause     <= '0;
      mtval      <= '0;
      trap_taken <= 1'b0;
      retired    <= '0;
    end else begin
      pc         <= pc_d;
      epc        <= epc_d;
      mcause     <= mcause_d;
      mtval      <= mtval_d;
      trap_taken <= trap_taken_d;
      retired    <= retired_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a vector table for the main configuration plus hand-written
// sequences for reset-under-stall, IALIGN=2 targets and a 4-bit retire counter wrap.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, jump, branch_taken, trap_req, trap_ret;
  logic [31:0] jump_target, branch_target;
  logic [3:0]  trap_cause;

  logic [31:0] pc, pc_plus4, epc, mtval, retired;
  logic [3:0]  mcause;
  logic        trap_taken;

  logic [31:0] pc2, pc_plus4_2, epc2, mtval2;
  logic [3:0]  mcause2, retired2;
  logic        trap_taken2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_ret(trap_ret),
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .mcause(mcause), .mtval(mtval),
    .trap_taken(trap_taken), .retired(retired)
  );

  pc_unit #(.IALIGN(2), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst), .stall(stall),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_ret(trap_ret),
    .pc(pc2), .pc_plus4(pc_plus4_2), .epc(epc2), .mcause(mcause2), .mtval(mtval2),
    .trap_taken(trap_taken2), .retired(retired2)
  );

  typedef struct {
    logic        stall;
    logic        jump;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        treq;
    logic [3:0]  tcause;
    logic        tret;
    logic [31:0] e_pc;
    logic [31:0] e_epc;
    logic [3:0]  e_mcause;
    logic [31:0] e_mtval;
    logic        e_tt;
    logic [31:0] e_ret;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; jump = 0; jump_target = '0; branch_taken = 0; branch_target = '0;
    trap_req = 0; trap_cause = '0; trap_ret = 0;
  endtask

  task automatic check_main(input string tag, input logic [31:0] e_pc, input logic [31:0] e_epc,
                            input logic [3:0] e_mc, input logic [31:0] e_tval,
                            input logic e_tt, input logic [31:0] e_ret);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
    check({tag, ".epc"}, epc, e_epc);
    check({tag, ".mcause"}, 32'(mcause), 32'(e_mc));
    check({tag, ".mtval"}, mtval, e_tval);
    check({tag, ".trap_taken"}, 32'(trap_taken), 32'(e_tt));
    check({tag, ".retired"}, retired, e_ret);
  endtask

  function automatic vec_t mk(logic s, logic j, logic [31:0] jt, logic b, logic [31:0] bt,
                              logic tq, logic [3:0] tc, logic tr,
                              logic [31:0] p, logic [31:0] ep, logic [3:0] mc,
                              logic [31:0] tv, logic tt, logic [31:0] rt);
    vec_t v;
    v.stall = s; v.jump = j; v.jt = jt; v.br = b; v.bt = bt;
    v.treq = tq; v.tcause = tc; v.tret = tr;
    v.e_pc = p; v.e_epc = ep; v.e_mcause = mc; v.e_mtval = tv; v.e_tt = tt; v.e_ret = rt;
    return v;
  endfunction

  initial begin
    //            stall jmp jt           br bt         treq cause ret  pc           epc     mc    mtval  tt ret
    vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,   0, 4'h0, 0, 32'h4,        32'h0,   4'h0, 32'h0,  0, 1);
    vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,   0, 4'h0, 0, 32'h8,        32'h0,   4'h0, 32'h0,  0, 2);
    vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,   0, 4'h0, 0, 32'hC,        32'h0,   4'h0, 32'h0,  0, 3);
    vecs[3]  = mk(0, 1, 32'h40,       1, 32'h80,  0, 4'h0, 0, 32'h40,       32'h0,   4'h0, 32'h0,  0, 4);
    vecs[4]  = mk(0, 0, 32'h0,        0, 32'h0,   1, 4'hB, 1, 32'h100,      32'h40,  4'hB, 32'h0,  1, 4);
    vecs[5]  = mk(0, 0, 32'h0,        0, 32'h0,   0, 4'h0, 1, 32'h40,       32'h40,  4'hB, 32'h0,  0, 5);
    vecs[6]  = mk(0, 1, 32'h10,       0, 32'h0,   0, 4'h0, 0, 32'h10,       32'h40,  4'hB, 32'h0,  0, 6);
    vecs[7]  = mk(0, 0, 32'h0,        1, 32'h22,  0, 4'h0, 0, 32'h100,      32'h10,  4'h0, 32'h22, 1, 6);
    vecs[8]  = mk(0, 1, 32'h41,       1, 32'h80,  0, 4'h0, 0, 32'h100,      32'h100, 4'h0, 32'h41, 1, 6);
    vecs[9]  = mk(0, 1, 32'h80,       0, 32'h0,   1, 4'h3, 0, 32'h100,      32'h100, 4'h3, 32'h0,  1, 6);
    vecs[10] = mk(0, 1, 32'h80,       0, 32'h0,   0, 4'h0, 1, 32'h100,      32'h100, 4'h3, 32'h0,  0, 7);
    vecs[11] = mk(0, 1, 32'h2,        0, 32'h0,   0, 4'h0, 0, 32'h100,      32'h100, 4'h0, 32'h2,  1, 7);
    vecs[12] = mk(0, 0, 32'h0,        1, 32'h200, 0, 4'h0, 0, 32'h200,      32'h100, 4'h0, 32'h2,  0, 8);
    vecs[13] = mk(1, 1, 32'h300,      0, 32'h0,   0, 4'h0, 0, 32'h200,      32'h100, 4'h0, 32'h2,  0, 8);
    vecs[14] = mk(1, 1, 32'h300,      0, 32'h0,   1, 4'h5, 0, 32'h200,      32'h100, 4'h0, 32'h2,  0, 8);
    vecs[15] = mk(1, 1, 32'h300,      0, 32'h0,   0, 4'h0, 1, 32'h200,      32'h100, 4'h0, 32'h2,  0, 8);
    vecs[16] = mk(0, 1, 32'h300,      0, 32'h0,   0, 4'h0, 0, 32'h300,      32'h100, 4'h0, 32'h2,  0, 9);
    vecs[17] = mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0,  0, 4'h0, 0, 32'hFFFF_FFFC, 32'h100, 4'h0, 32'h2,  0, 10);
    vecs[18] = mk(0, 0, 32'h0,        0, 32'h0,   0, 4'h0, 0, 32'h0,        32'h100, 4'h0, 32'h2,  0, 11);
    vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,   0, 4'h0, 1, 32'h100,      32'h100, 4'h0, 32'h2,  0, 12);

    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    check_main("reset", 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 32'd0);

    for (int i = 0; i < 20; i++) begin
      stall = vecs[i].stall; jump = vecs[i].jump; jump_target = vecs[i].jt;
      branch_taken = vecs[i].br; branch_target = vecs[i].bt;
      trap_req = vecs[i].treq; trap_cause = vecs[i].tcause; trap_ret = vecs[i].tret;
      step();
      check_main($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_epc, vecs[i].e_mcause,
                 vecs[i].e_mtval, vecs[i].e_tt, vecs[i].e_ret);
    end

    // Reset while stalled with a redirect pending.
    stall = 1; jump = 1; jump_target = 32'h500; rst = 1;
    step();
    rst = 0;
    check_main("rst_in_stall", 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 32'd0);
    check("rst_in_stall.pc2", pc2, 32'h0);
    check("rst_in_stall.retired2", 32'(retired2), 32'd0);

    // IALIGN=2 accepts a halfword-aligned target the default instance rejects.
    idle_inputs();
    jump = 1; jump_target = 32'h10;
    step();
    check("ialign2.jump.pc2", pc2, 32'h10);
    idle_inputs();
    branch_taken = 1; branch_target = 32'h22;
    step();
    check("ialign2.br.pc2", pc2, 32'h22);
    check("ialign2.br.tt2", 32'(trap_taken2), 32'd0);
    check("ialign2.br.retired2", 32'(retired2), 32'd2);
    check("ialign4.br.pc", pc, 32'h100);
    check("ialign4.br.epc", epc, 32'h10);
    check("ialign4.br.mtval", mtval, 32'h22);
    check("ialign4.br.tt", 32'(trap_taken), 32'd1);
    check("ialign4.br.retired", retired, 32'd1);

    // Fourteen more retires bring the 4-bit counter to 16, i.e. wrap to zero.
    idle_inputs();
    for (int i = 0; i < 14; i++) step();
    check("cnt4.wrap.retired2", 32'(retired2), 32'd0);
    check("cnt4.wrap.pc2", pc2, 32'h5A);
    check("cnt32.retired", retired, 32'd15);

    // Odd target still faults under IALIGN=2.
    jump = 1; jump_target = 32'h21;
    step();
    idle_inputs();
    check("ialign2.odd.pc2", pc2, 32'h100);
    check("ialign2.odd.epc2", epc2, 32'h5A);
    check("ialign2.odd.mtval2", mtval2, 32'h21);
    check("ialign2.odd.tt2", 32'(trap_taken2), 32'd1);
    check("ialign2.odd.retired2", 32'(retired2), 32'd0);
    step();
    check("ialign2.odd.tt2_drop", 32'(trap_taken2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
